// File: rtl/max7219_receiver.sv
// MAX7219 three-wire (DIN/CLK/LOAD) device-side receiver with a MAX7219-compatible register file.
// Optional MAX7219_RECEIVER_FRAME_CHECK_EN drops short frames and pulses out_error instead.
module max7219_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_data,
    input  logic        in_clock,
    input  logic        in_load,
    output logic        out_valid,
    output logic [15:0] out_word,
    output logic        out_error,
    output logic [63:0] out_digits,
    output logic [7:0]  out_decode_mode,
    output logic [3:0]  out_intensity,
    output logic [2:0]  out_scan_limit,
    output logic        out_shutdown,
    output logic        out_display_test
);

    logic [SYNC_STAGES-1:0] r_sync_din;
    logic [SYNC_STAGES-1:0] r_sync_clk;
    logic [SYNC_STAGES-1:0] r_sync_load;
    logic                   r_hist_clk;
    logic                   r_hist_load;

    logic [15:0] r_shift;
    logic [4:0]  r_count;
    logic        r_valid;
    logic [15:0] r_word;
    logic        r_error;
    logic [63:0] r_digits;
    logic [7:0]  r_decode;
    logic [3:0]  r_intensity;
    logic [2:0]  r_scan;
    logic        r_shutdown;
    logic        r_dtest;

    logic        w_din;
    logic        w_clk_rise;
    logic        w_load_rise;
    logic [15:0] w_shift_next;
    logic [4:0]  w_count_next;
    logic [3:0]  w_addr;
    logic [2:0]  w_digit_sel;
    logic        w_frame_ok;
    logic        w_commit;
    logic        w_reject;

    // Synchronizers plus one history flop per wire; DIN shares the same depth as CLK so they stay aligned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync_din  <= '0;
            r_sync_clk  <= '0;
            r_sync_load <= '0;
            r_hist_clk  <= 1'b0;
            r_hist_load <= 1'b0;
        end else begin
            r_sync_din  <= {r_sync_din[SYNC_STAGES-2:0], in_data};
            r_sync_clk  <= {r_sync_clk[SYNC_STAGES-2:0], in_clock};
            r_sync_load <= {r_sync_load[SYNC_STAGES-2:0], in_load};
            r_hist_clk  <= r_sync_clk[SYNC_STAGES-1];
            r_hist_load <= r_sync_load[SYNC_STAGES-1];
        end
    end

    assign w_din       = r_sync_din[SYNC_STAGES-1];
    assign w_clk_rise  = r_sync_clk[SYNC_STAGES-1] & ~r_hist_clk;
    assign w_load_rise = r_sync_load[SYNC_STAGES-1] & ~r_hist_load;

    // A CLK edge coinciding with LOAD shifts first, so the commit sees the new bit.
    always_comb begin
        w_shift_next = r_shift;
        w_count_next = r_count;
        if (w_clk_rise) begin
            w_shift_next = {r_shift[14:0], w_din};
            w_count_next = (r_count == 5'd16) ? 5'd16 : r_count + 5'd1;
        end
    end

`ifdef MAX7219_RECEIVER_FRAME_CHECK_EN
    assign w_frame_ok = (w_count_next == 5'd16);
`else
    assign w_frame_ok = 1'b1;
`endif

    assign w_commit    = w_load_rise & w_frame_ok;
    assign w_reject    = w_load_rise & ~w_frame_ok;
    assign w_addr      = w_shift_next[11:8];
    assign w_digit_sel = w_addr[2:0] - 3'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_word      <= '0;
            r_error     <= 1'b0;
            r_digits    <= '0;
            r_decode    <= '0;
            r_intensity <= '0;
            r_scan      <= '0;
            r_shutdown  <= 1'b1;
            r_dtest     <= 1'b0;
        end else begin
            r_shift <= w_shift_next;
            r_count <= w_load_rise ? 5'd0 : w_count_next;
            r_valid <= w_commit;
            r_error <= w_reject;
            if (w_commit) begin
                r_word <= w_shift_next;
                case (w_addr)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: r_digits[{w_digit_sel, 3'b000} +: 8] <= w_shift_next[7:0];
                    4'h9:    r_decode    <= w_shift_next[7:0];
                    4'hA:    r_intensity <= w_shift_next[3:0];
                    4'hB:    r_scan      <= w_shift_next[2:0];
                    4'hC:    r_shutdown  <= ~w_shift_next[0];
                    4'hF:    r_dtest     <= w_shift_next[0];
                    default: ;
                endcase
            end
        end
    end

    assign out_valid        = r_valid;
    assign out_word         = r_word;
    assign out_error        = r_error;
    assign out_digits       = r_digits;
    assign out_decode_mode  = r_decode;
    assign out_intensity    = r_intensity;
    assign out_scan_limit   = r_scan;
    assign out_shutdown     = r_shutdown;
    assign out_display_test = r_dtest;

endmodule

// File: tb/tb_max7219_receiver.sv
// Scoreboard bench for max7219_receiver: directed frames push expected register snapshots,
// a negedge monitor pops one per out_valid/out_error pulse.
module tb_max7219_receiver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_data = 1'b0;
    logic        in_clock = 1'b0;
    logic        in_load = 1'b0;
    logic        out_valid;
    logic [15:0] out_word;
    logic        out_error;
    logic [63:0] out_digits;
    logic [7:0]  out_decode_mode;
    logic [3:0]  out_intensity;
    logic [2:0]  out_scan_limit;
    logic        out_shutdown;
    logic        out_display_test;

    max7219_receiver #(.SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_clock(in_clock), .in_load(in_load),
        .out_valid(out_valid), .out_word(out_word), .out_error(out_error),
        .out_digits(out_digits), .out_decode_mode(out_decode_mode),
        .out_intensity(out_intensity), .out_scan_limit(out_scan_limit),
        .out_shutdown(out_shutdown), .out_display_test(out_display_test)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        err;
        logic [15:0] word;
        logic [63:0] digits;
        logic [7:0]  dec;
        logic [3:0]  inten;
        logic [2:0]  scan;
        logic        shut;
        logic        dt;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic set_defaults();
        cur.err = 1'b0; cur.word = 16'h0; cur.digits = 64'h0; cur.dec = 8'h0;
        cur.inten = 4'h0; cur.scan = 3'h0; cur.shut = 1'b1; cur.dt = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            in_data  = val[i];
            cycles(4);
            in_clock = 1'b1;
            cycles(4);
            in_clock = 1'b0;
        end
    endtask

    task automatic pulse_load();
        cycles(4);
        in_load = 1'b1;
        cycles(4);
        in_load = 1'b0;
        cycles(4);
    endtask

    task automatic check_resets();
        chk("rst_valid", out_valid, 0);
        chk("rst_word", out_word, 0);
        chk("rst_error", out_error, 0);
        chk("rst_digits", out_digits, 0);
        chk("rst_decode", out_decode_mode, 0);
        chk("rst_intensity", out_intensity, 0);
        chk("rst_scan", out_scan_limit, 0);
        chk("rst_shutdown", out_shutdown, 1);
        chk("rst_dtest", out_display_test, 0);
    endtask

    // Monitor: every output pulse must match the oldest expected snapshot.
    always @(negedge clock) begin
        if (!reset && (out_valid || out_error)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {out_valid, out_error, out_word}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid", out_valid, !e.err);
                chk("error", out_error, e.err);
                chk("word", out_word, e.word);
                chk("digits", out_digits, e.digits);
                chk("decode", out_decode_mode, e.dec);
                chk("intensity", out_intensity, e.inten);
                chk("scan", out_scan_limit, e.scan);
                chk("shutdown", out_shutdown, e.shut);
                chk("dtest", out_display_test, e.dt);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_defaults();
        cycles(3);
        check_resets();
        reset = 1'b0;
        cycles(4);

        // Short 8-bit frame straight after reset: shift register holds 0x00A5.
`ifdef MAX7219_RECEIVER_FRAME_CHECK_EN
        cur.err = 1'b1;
        sb.push_back(cur);
        cur.err = 1'b0;
`else
        cur.word = 16'h00A5;
        sb.push_back(cur);
`endif
        send_bits(32'hA5, 8);
        pulse_load();

        cur.word = 16'h0A05; cur.inten = 4'h5;
        sb.push_back(cur);
        send_bits(32'h0A05, 16);
        pulse_load();

        cur.word = 16'h0103; cur.digits[7:0] = 8'h03;
        sb.push_back(cur);
        send_bits(32'h0103, 16);
        pulse_load();

        cur.word = 16'h08F0; cur.digits[63:56] = 8'hF0;
        sb.push_back(cur);
        send_bits(32'h08F0, 16);
        pulse_load();
        chk("digits_only_0_7", out_digits, 64'hF000_0000_0000_0003);

        cur.word = 16'h0C01; cur.shut = 1'b0;
        sb.push_back(cur);
        send_bits(32'h0C01, 16);
        pulse_load();

        cur.word = 16'h0C00; cur.shut = 1'b1;
        sb.push_back(cur);
        send_bits(32'h0C00, 16);
        pulse_load();

        cur.word = 16'h0D55;
        sb.push_back(cur);
        send_bits(32'h0D55, 16);
        pulse_load();

        // 20-bit frame: leading 0xF nibble falls off, 0x0F01 is committed.
        cur.word = 16'h0F01; cur.dt = 1'b1;
        sb.push_back(cur);
        send_bits(32'hF_0F01, 20);
        pulse_load();

        // Abort a frame with reset after 9 bits; everything returns to reset values.
        send_bits(32'h1FF, 9);
        cycles(2);
        reset = 1'b1;
        cycles(3);
        check_resets();
        reset = 1'b0;
        set_defaults();
        cycles(4);

        cur.word = 16'h0B07; cur.scan = 3'h7;
        sb.push_back(cur);
        send_bits(32'h0B07, 16);
        pulse_load();

        // 15 bits, then the 16th CLK edge and the LOAD edge arrive together.
        cur.word = 16'h0901; cur.dec = 8'h01;
        sb.push_back(cur);
        send_bits(32'h0480, 15);
        in_data = 1'b1;
        cycles(4);
        in_clock = 1'b1;
        in_load  = 1'b1;
        cycles(4);
        in_clock = 1'b0;
        in_load  = 1'b0;
        cycles(4);

        for (int i = 0; i < 50 && sb.size() != 0; i++) cycles(1);
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_decode", out_decode_mode, 8'h01);
        chk("final_scan", out_scan_limit, 3'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
